multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 85 ++++++++
 rtl/mc_outdec.sv | 87 ++++++++
 rtl/multicycle_ctrl.sv | 122 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode/funct values, ALUOp codes and the packed control word.
package mips_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StIExec  = 4'd8,
    StIwb    = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11,
    StJal    = 4'd12,
    StJr     = 4'd13,
    StHalt   = 4'd14
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FunctJr = 6'b001000;

  localparam logic [3:0] AluFunct = 4'b0000; // ALU control decodes funct
  localparam logic [3:0] AluAdd   = 4'b1000;
  localparam logic [3:0] AluSub   = 4'b1001;
  localparam logic [3:0] AluAnd   = 4'b1010;
  localparam logic [3:0] AluOr    = 4'b1011;
  localparam logic [3:0] AluXor   = 4'b1100;
  localparam logic [3:0] AluSlt   = 4'b1101;
  localparam logic [3:0] AluSltu  = 4'b1110;
  localparam logic [3:0] AluLui   = 4'b1111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       bne;
    logic       ior_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       zero_ext;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_imm_op(logic [5:0] op);
    return (op == OpAddi) || (op == OpSlti) || (op == OpSltiu) || (op == OpAndi) ||
           (op == OpOri)  || (op == OpXori) || (op == OpLui);
  endfunction

  function automatic logic [3:0] imm_alu_op(logic [5:0] op);
    case (op)
      OpSlti:  return AluSlt;
      OpSltiu: return AluSltu;
      OpAndi:  return AluAnd;
      OpOri:   return AluOr;
      OpXori:  return AluXor;
      OpLui:   return AluLui;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational control-word decode for the multicycle controller.
// Ports: state      - current FSM state
//        opcode     - opcode latched for the current instruction
//        fetch_done - instruction fetch completes this cycle
//        ctrl       - decoded control word
module mc_outdec
  import mips_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       fetch_done,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = AluAdd;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = fetch_done;
        ctrl.pc_write  = fetch_done;
      end
      StDecode: ctrl.alu_src_b = 2'b11; // branch target precompute
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 2'b01;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluFunct;
      end
      StRwb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 2'b01;
      end
      StIExec, StIwb: begin
        // ALUOp/zeroExt stay valid through write-back
        ctrl.alu_op   = imm_alu_op(opcode);
        ctrl.zero_ext = (opcode == OpAndi) || (opcode == OpOri) || (opcode == OpXori);
        if (state == StIExec) begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
        end else begin
          ctrl.reg_write = 1'b1;
        end
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = AluSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.bne           = (opcode == OpBne);
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      StJal: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b10;
      end
      StJr: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: FSM, opcode/funct latch, retire counter.
// Inputs:  clk, rst_n, opcode/funct (IR fields), zero, mem_ready.
// Outputs: datapath control signals, current state, sticky illegal flag,
//          retired-instruction count.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MEM_HS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               bne,
  output logic               iorD,
  output logic               irWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic [1:0]         regDst,
  output logic [1:0]         memToReg,
  output logic               regWrite,
  output logic               zeroExt,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         pcSource,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, funct_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             ready, fetch_done, retire;
  ctrl_t            ctrl;

  // Branch resolution happens in the datapath from pcWriteCond/bne/zero.
  logic unused_zero;
  assign unused_zero = zero;

  assign ready      = (MEM_HS == 0) || mem_ready;
  assign fetch_done = (state_q == StFetch) && ready;
  assign retire     = (state_q != StFetch) && (state_d == StFetch);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (ready) state_d = StDecode;
      StDecode: begin
        case (op_q)
          OpRtype:     state_d = (funct_q == FunctJr) ? StJr : StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:         state_d = StJump;
          OpJal:       state_d = StJal;
          default:     state_d = is_imm_op(op_q) ? StIExec : StHalt;
        endcase
      end
      StMemAdr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (ready) state_d = StMemWb;
      StMemWr:  if (ready) state_d = StFetch;
      StExec:   state_d = StRwb;
      StIExec:  state_d = StIwb;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch; // all other final states
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      op_q      <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (fetch_done) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      if (state_d == StHalt) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  mc_outdec u_outdec (
    .state      (state_q),
    .opcode     (op_q),
    .fetch_done (fetch_done),
    .ctrl       (ctrl)
  );

  // Write enables are forced low combinationally while reset is held.
  assign pcWrite     = ctrl.pc_write & rst_n;
  assign pcWriteCond = ctrl.pc_write_cond & rst_n;
  assign irWrite     = ctrl.ir_write & rst_n;
  assign memWrite    = ctrl.mem_write & rst_n;
  assign regWrite    = ctrl.reg_write & rst_n;
  assign bne         = ctrl.bne;
  assign iorD        = ctrl.ior_d;
  assign memRead     = ctrl.mem_read;
  assign regDst      = ctrl.reg_dst;
  assign memToReg    = ctrl.mem_to_reg;
  assign zeroExt     = ctrl.zero_ext;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ALUOP_W'(ctrl.alu_op);
  assign pcSource    = ctrl.pc_source;
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pcWrite, pcWriteCond, bne, iorD, irWrite, memRead, memWrite;
  logic [1:0]  regDst, memToReg, ALUSrcB, pcSource;
  logic        regWrite, zeroExt, ALUSrcA, illegal;
  logic [3:0]  ALUOp, state;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .bne(bne),
    .iorD(iorD), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite), .zeroExt(zeroExt),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .pcSource(pcSource),
    .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [3:0] exp);
    checks++;
    if (state !== exp) begin
      errors++;
      $display("FAIL %s: state=%0d expected %0d", name, state, exp);
    end
  endtask

  task automatic chk_retired(input string name);
    checks++;
    if (retired !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL %s: retired=%0d expected %0d", name, retired, exp_ret);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    step();
    step();
    chk_state("reset_state", 4'd0);
    checks++;
    if ({illegal, retired} !== 33'd0) begin
      errors++;
      $display("FAIL reset_flags: illegal=%b retired=%0d expected 0 0", illegal, retired);
    end
    checks++;
    if ({pcWrite, irWrite, memWrite, regWrite, pcWriteCond} !== 5'b0) begin
      errors++;
      $display("FAIL reset_we: we=%b expected 00000",
               {pcWrite, irWrite, memWrite, regWrite, pcWriteCond});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({memRead, iorD, ALUSrcA, ALUSrcB, ALUOp, irWrite, pcWrite} !== 11'b1_0_0_01_1000_1_1) begin
      errors++;
      $display("FAIL fetch_outputs: got %b expected 10001100011",
               {memRead, iorD, ALUSrcA, ALUSrcB, ALUOp, irWrite, pcWrite});
    end
  endtask

  task automatic test_add();
    opcode = 6'b000000;
    funct = 6'b100000;
    step();
    chk_state("add_decode", 4'd1);
    checks++;
    if ({ALUSrcA, ALUSrcB, ALUOp} !== 7'b0_11_1000) begin
      errors++;
      $display("FAIL decode_outputs: got %b expected 0111000", {ALUSrcA, ALUSrcB, ALUOp});
    end
    opcode = 6'b111111; // must not disturb the latched instruction
    step();
    chk_state("add_exec", 4'd6);
    checks++;
    if ({ALUSrcA, ALUSrcB, ALUOp} !== 7'b1_00_0000) begin
      errors++;
      $display("FAIL exec_outputs: got %b expected 1000000", {ALUSrcA, ALUSrcB, ALUOp});
    end
    step();
    chk_state("add_rwb", 4'd7);
    checks++;
    if ({regWrite, regDst, memToReg} !== 5'b1_01_00) begin
      errors++;
      $display("FAIL rwb_outputs: got %b expected 10100", {regWrite, regDst, memToReg});
    end
    chk_retired("add_before_retire");
    step();
    exp_ret++;
    chk_state("add_fetch", 4'd0);
    chk_retired("add_retired");
  endtask

  task automatic test_lw();
    int cyc = 1;
    opcode = 6'b100011;
    step(); cyc++;
    step(); cyc++;
    chk_state("lw_memadr", 4'd2);
    checks++;
    if ({ALUSrcA, ALUSrcB, ALUOp} !== 7'b1_10_1000) begin
      errors++;
      $display("FAIL memadr_outputs: got %b expected 1101000", {ALUSrcA, ALUSrcB, ALUOp});
    end
    mem_ready = 1'b0;
    step(); cyc++;
    for (int i = 0; i < 3; i++) begin
      chk_state("lw_memrd_wait", 4'd3);
      step(); cyc++;
    end
    chk_state("lw_memrd", 4'd3);
    checks++;
    if ({memRead, iorD} !== 2'b11) begin
      errors++;
      $display("FAIL memrd_outputs: got %b expected 11", {memRead, iorD});
    end
    mem_ready = 1'b1;
    step(); cyc++;
    chk_state("lw_memwb", 4'd4);
    checks++;
    if ({regWrite, regDst, memToReg, cyc[3:0]} !== {5'b1_00_01, 4'd8}) begin
      errors++;
      $display("FAIL memwb_outputs: got %b cycle=%0d expected 10001 cycle=8",
               {regWrite, regDst, memToReg}, cyc);
    end
    step();
    exp_ret++;
    chk_retired("lw_retired");
  endtask

  task automatic test_sw();
    opcode = 6'b101011;
    step();
    step();
    step();
    chk_state("sw_memwr", 4'd5);
    checks++;
    if ({memWrite, iorD, memRead} !== 3'b110) begin
      errors++;
      $display("FAIL memwr_outputs: got %b expected 110", {memWrite, iorD, memRead});
    end
    step();
    exp_ret++;
    chk_state("sw_fetch", 4'd0);
    checks++;
    if (memWrite !== 1'b0) begin
      errors++;
      $display("FAIL sw_memwrite_drop: memWrite=%b expected 0", memWrite);
    end
    chk_retired("sw_retired");
  endtask

  task automatic test_branch(input logic [5:0] op, input logic exp_bne);
    opcode = op;
    zero = 1'b0;
    step();
    step();
    chk_state("branch_state", 4'd10);
    checks++;
    if ({pcWriteCond, bne, pcSource, ALUOp, ALUSrcA, ALUSrcB, pcWrite} !==
        {1'b1, exp_bne, 2'b01, 4'b1001, 1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL branch_outputs op=%b: got %b expected %b", op,
               {pcWriteCond, bne, pcSource, ALUOp, ALUSrcA, ALUSrcB, pcWrite},
               {1'b1, exp_bne, 2'b01, 4'b1001, 1'b1, 2'b00, 1'b0});
    end
    step();
    exp_ret++;
    chk_retired("branch_retired");
  endtask

  task automatic test_ori();
    opcode = 6'b001101;
    step();
    step();
    chk_state("ori_iexec", 4'd8);
    checks++;
    if ({ALUSrcA, ALUSrcB, ALUOp, zeroExt} !== 8'b1_10_1011_1) begin
      errors++;
      $display("FAIL iexec_outputs: got %b expected 11010111", {ALUSrcA, ALUSrcB, ALUOp, zeroExt});
    end
    step();
    chk_state("ori_iwb", 4'd9);
    checks++;
    if ({regWrite, regDst, memToReg, ALUOp, zeroExt} !== 10'b1_00_00_1011_1) begin
      errors++;
      $display("FAIL iwb_outputs: got %b expected 1000010111",
               {regWrite, regDst, memToReg, ALUOp, zeroExt});
    end
    step();
    exp_ret++;
    chk_retired("ori_retired");
  endtask

  task automatic test_jal();
    opcode = 6'b000011;
    step();
    step();
    chk_state("jal_state", 4'd12);
    checks++;
    if ({pcWrite, pcSource, regWrite, regDst, memToReg} !== 8'b1_10_1_10_10) begin
      errors++;
      $display("FAIL jal_outputs: got %b expected 11011010",
               {pcWrite, pcSource, regWrite, regDst, memToReg});
    end
    step();
    exp_ret++;
    chk_retired("jal_retired");
  endtask

  task automatic test_jr();
    opcode = 6'b000000;
    funct = 6'b001000;
    step();
    step();
    chk_state("jr_state", 4'd13);
    checks++;
    if ({pcWrite, pcSource, regWrite} !== 4'b1_11_0) begin
      errors++;
      $display("FAIL jr_outputs: got %b expected 1110", {pcWrite, pcSource, regWrite});
    end
    step();
    exp_ret++;
    chk_retired("jr_retired");
    funct = 6'b100000;
  endtask

  task automatic test_reset_memwr();
    opcode = 6'b101011;
    step();
    step();
    mem_ready = 1'b0;
    step();
    step();
    chk_state("memwr_held", 4'd5);
    checks++;
    if (memWrite !== 1'b1) begin
      errors++;
      $display("FAIL memwr_held_we: memWrite=%b expected 1", memWrite);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_ret = 0;
    checks++;
    if ({memWrite, state} !== 5'b0_0000) begin
      errors++;
      $display("FAIL memwr_reset_async: memWrite=%b state=%0d expected 0 0", memWrite, state);
    end
    chk_retired("memwr_reset_retired");
    mem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    chk_state("memwr_release_fetch", 4'd0);
    opcode = 6'b000000;
    step();
    chk_state("memwr_release_decode", 4'd1);
    chk_retired("memwr_no_retire");
    step();
    step();
    step();
    exp_ret++;
    chk_retired("after_reset_add_retired");
  endtask

  task automatic test_halt();
    opcode = 6'b111111;
    step();
    step();
    chk_state("halt_state", 4'd14);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({state, illegal, regWrite, memWrite, pcWrite, pcWriteCond, irWrite} !==
          {4'd14, 1'b1, 5'b0}) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: state=%0d illegal=%b we=%b expected 14 1 00000",
                 i, state, illegal, {regWrite, memWrite, pcWrite, pcWriteCond, irWrite});
      end
      step();
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({state, illegal} !== 5'b0000_0) begin
      errors++;
      $display("FAIL halt_reset: state=%0d illegal=%b expected 0 0", state, illegal);
    end
    step();
    rst_n = 1'b1;
    opcode = 6'b000000;
    step();
    chk_state("halt_release_decode", 4'd1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_branch(6'b000101, 1'b1);
    test_branch(6'b000100, 1'b0);
    test_ori();
    test_jal();
    test_jr();
    test_reset_memwr();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
